// File: rtl/gray_step_tracker_pkg.sv
// Shared types for the Gray-code step tracker.
// Holds the Gray word width and the tracker FSM state encoding.
package gray_step_tracker_pkg;
  localparam int GRAY_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;
endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin
  import gray_step_tracker_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  always_comb begin
    bin = gray;
    for (int i = 1; i < GRAY_W; i++) begin
      bin = bin ^ (gray >> i);
    end
  end

endmodule

// File: rtl/gray_step_tracker.sv
// Decodes a sampled Gray position and classifies each sample as up, down, hold or illegal jump.
// All results are registered one clock after in_valid; there is no backpressure.
module gray_step_tracker
  import gray_step_tracker_pkg::*;
#(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [GRAY_W-1:0] gray_in,
  input  logic              clr,
  output logic              out_valid,
  output logic [GRAY_W-1:0] bin_out,
  output logic              step_up,
  output logic              step_down,
  output logic              step_err,
  output logic [POS_W-1:0]  pos,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [GRAY_W-1:0] bin_dec;
  logic [GRAY_W-1:0] baseline;
  logic [GRAY_W-1:0] diff;
  logic              up_c;
  logic              down_c;
  logic              err_c;

  gray_to_bin u_dec (
    .gray (gray_in),
    .bin  (bin_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      state_nxt = TRACK;
    end
  end

  // Modulo-16 difference; the IDLE sample only establishes the baseline.
  always_comb begin
    diff   = bin_dec - baseline;
    up_c   = 1'b0;
    down_c = 1'b0;
    err_c  = 1'b0;
    if (in_valid && state == TRACK) begin
      case (diff)
        GRAY_W'(0):  ;
        GRAY_W'(1):  up_c   = 1'b1;
        GRAY_W'(15): down_c = 1'b1;
        default:     err_c  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baseline  <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_err  <= 1'b0;
      pos       <= '0;
      err_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      step_up   <= up_c;
      step_down <= down_c;
      step_err  <= err_c;
      if (in_valid) begin
        baseline <= bin_dec;
        bin_out  <= bin_dec;
      end
      // clr overrides any same-cycle accumulator update.
      if (clr) begin
        pos     <= '0;
        err_cnt <= '0;
      end else begin
        if (up_c) begin
          pos <= pos + POS_W'(1);
        end else if (down_c) begin
          pos <= pos - POS_W'(1);
        end
        if (err_c && err_cnt != {ERR_W{1'b1}}) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Scoreboard bench for gray_step_tracker: a reference model pushes expected outputs per cycle.
module tb_gray_step_tracker;

  typedef struct packed {
    logic       ov;
    logic [3:0] bin;
    logic       up;
    logic       dn;
    logic       er;
    logic [7:0] pos;
    logic [3:0] err;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] gray_in;
  logic       clr;
  logic       out_valid;
  logic [3:0] bin_out;
  logic       step_up;
  logic       step_down;
  logic       step_err;
  logic [7:0] pos;
  logic [3:0] err_cnt;

  obs_t q[$];
  int   checks = 0;
  int   passes = 0;

  logic       m_track;
  logic [3:0] m_base;
  logic [3:0] m_bin;
  logic [7:0] m_pos;
  logic [3:0] m_err;

  gray_step_tracker #(.POS_W(8), .ERR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .clr       (clr),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .step_up   (step_up),
    .step_down (step_down),
    .step_err  (step_err),
    .pos       (pos),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t dut_obs();
    return {out_valid, bin_out, step_up, step_down, step_err, pos, err_cnt};
  endfunction

  // Drives one cycle, updates the model and queues what the DUT must show afterwards.
  task automatic drive(input logic v, input logic [3:0] g, input logic c);
    obs_t       e;
    logic [3:0] b;
    logic [3:0] d;
    @(negedge clk);
    in_valid = v;
    gray_in  = g;
    clr      = c;
    b = {g[3], g[3]^g[2], g[3]^g[2]^g[1], g[3]^g[2]^g[1]^g[0]};
    e = '0;
    e.ov = v;
    if (v) begin
      if (m_track) begin
        d = b - m_base;
        if (d == 4'd1) begin
          e.up = 1'b1;
          m_pos = m_pos + 8'd1;
        end else if (d == 4'd15) begin
          e.dn = 1'b1;
          m_pos = m_pos - 8'd1;
        end else if (d != 4'd0) begin
          e.er = 1'b1;
          if (m_err != 4'd15) m_err = m_err + 4'd1;
        end
      end
      m_track = 1'b1;
      m_base  = b;
      m_bin   = b;
    end
    if (c) begin
      m_pos = '0;
      m_err = '0;
    end
    e.bin = m_bin;
    e.pos = m_pos;
    e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_track = 1'b0;
    m_base  = '0;
    m_bin   = '0;
    m_pos   = '0;
    m_err   = '0;
    q.push_back('0);
  endtask

  task automatic test_reset();
    obs_t e;
    apply_reset(2);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL reset_outputs got %h want %h", dut_obs(), e);
    else passes++;
    rst_n = 1'b1;
    drive(1'b1, 4'b0000, 1'b0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL first_sample got %h want %h", dut_obs(), e);
    else passes++;
    checks++;
    if (out_valid !== 1'b1 || step_up !== 1'b0 || step_down !== 1'b0 || pos !== 8'd0)
      $display("FAIL first_no_step got ov=%b up=%b dn=%b pos=%0d want ov=1 up=0 dn=0 pos=0",
               out_valid, step_up, step_down, pos);
    else passes++;
  endtask

  task automatic test_steps();
    logic [3:0] seq [3];
    obs_t e;
    seq = '{4'b0001, 4'b0000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq[i], 1'b0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) $display("FAIL steps[%0d] got %h want %h", i, dut_obs(), e);
      else passes++;
    end
    checks++;
    if (step_down !== 1'b1 || pos !== 8'd255 || bin_out !== 4'd15)
      $display("FAIL pos_underflow got dn=%b pos=%0d bin=%0d want dn=1 pos=255 bin=15",
               step_down, pos, bin_out);
    else passes++;
  endtask

  task automatic test_wrap_hold();
    logic [3:0] seq [3];
    logic       vld [3];
    obs_t e;
    seq = '{4'b0000, 4'b0000, 4'b0101};
    vld = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(vld[i], seq[i], 1'b0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) $display("FAIL wrap_hold[%0d] got %h want %h", i, dut_obs(), e);
      else passes++;
    end
  endtask

  task automatic test_errors();
    obs_t e;
    drive(1'b1, 4'b0100, 1'b0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL err_first got %h want %h", dut_obs(), e);
    else passes++;
    checks++;
    if (step_err !== 1'b1 || err_cnt !== 4'd1 || bin_out !== 4'b0111)
      $display("FAIL err_decode got er=%b cnt=%0d bin=%b want er=1 cnt=1 bin=0111",
               step_err, err_cnt, bin_out);
    else passes++;
    drive(1'b1, 4'b1100, 1'b0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e || step_up !== 1'b1) $display("FAIL err_resync got %h want %h", dut_obs(), e);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, to_gray((i % 2 == 0) ? 4'd0 : 4'd8), 1'b0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) $display("FAIL err_sat[%0d] got %h want %h", i, dut_obs(), e);
      else passes++;
    end
    checks++;
    if (err_cnt !== 4'd15) $display("FAIL err_saturate got %0d want 15", err_cnt);
    else passes++;
  endtask

  task automatic test_clr();
    obs_t e;
    drive(1'b0, 4'b0000, 1'b1);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL clr_alone got %h want %h", dut_obs(), e);
    else passes++;
    for (int i = 9; i <= 13; i++) begin
      drive(1'b1, to_gray(4'(i)), 1'b0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) $display("FAIL clr_ramp[%0d] got %h want %h", i, dut_obs(), e);
      else passes++;
    end
    checks++;
    if (pos !== 8'd5) $display("FAIL clr_pre_pos got %0d want 5", pos);
    else passes++;
    drive(1'b1, to_gray(4'd14), 1'b1);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL clr_with_step got %h want %h", dut_obs(), e);
    else passes++;
    checks++;
    if (step_up !== 1'b1 || pos !== 8'd0 || err_cnt !== 4'd0 || bin_out !== 4'd14)
      $display("FAIL clr_wins got up=%b pos=%0d cnt=%0d bin=%0d want up=1 pos=0 cnt=0 bin=14",
               step_up, pos, err_cnt, bin_out);
    else passes++;
  endtask

  task automatic test_midstream_reset();
    obs_t e;
    apply_reset(1);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL mid_reset got %h want %h", dut_obs(), e);
    else passes++;
    rst_n = 1'b1;
    drive(1'b1, to_gray(4'd15), 1'b0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) $display("FAIL mid_reset_capture got %h want %h", dut_obs(), e);
    else passes++;
    checks++;
    if (out_valid !== 1'b1 || step_up !== 1'b0 || step_down !== 1'b0 || step_err !== 1'b0)
      $display("FAIL mid_reset_no_pulse got ov=%b up=%b dn=%b er=%b want 1 0 0 0",
               out_valid, step_up, step_down, step_err);
    else passes++;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    gray_in  = '0;
    clr      = 1'b0;
    m_track  = 1'b0;
    m_base   = '0;
    m_bin    = '0;
    m_pos    = '0;
    m_err    = '0;
    test_reset();
    test_steps();
    test_wrap_hold();
    test_errors();
    test_clr();
    test_midstream_reset();
    checks++;
    if (q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
